// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor record exchanged with the CSR block.
package uart_pkg;

  localparam int unsigned OS_RATE_DEF = 16;
  localparam int unsigned DIV_W_DEF   = 16;
  localparam int unsigned FRAC_W_DEF  = 4;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

  // Oversample rate must be a power of two and at least 4.
  function automatic bit os_rate_ok(int unsigned rate);
    return (rate >= 4) && ((rate & (rate - 1)) == 0);
  endfunction

endpackage

// File: rtl/baud_frac_prescaler.sv
// Fractional prescaler: integer period div_int+1 with a carry-dithered extra clock
// so the mean period is div_int + 1 + div_frac/2^FRAC_W clocks.
module baud_frac_prescaler #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              wrap_o,
  output logic              os_tick_o
);

  // One extra bit so div_int at max plus a carry still has a reachable terminal count.
  logic [DIV_W:0]    pre_cnt_q, pre_cnt_d;
  logic [DIV_W:0]    limit;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              carry_q, carry_d;
  logic              os_tick_q, os_tick_d;
  logic              wrap;

  // Next-state: count to limit, then restart and accumulate the fractional part.
  always_comb begin
    limit      = {1'b0, div_int_i} + {{DIV_W{1'b0}}, carry_q};
    wrap       = en_i && (pre_cnt_q == limit);
    pre_cnt_d  = pre_cnt_q;
    frac_acc_d = frac_acc_q;
    carry_d    = carry_q;
    os_tick_d  = 1'b0;
    if (!en_i) begin
      pre_cnt_d  = '0;
      frac_acc_d = '0;
      carry_d    = 1'b0;
    end else if (wrap) begin
      pre_cnt_d             = '0;
      {carry_d, frac_acc_d} = {1'b0, frac_acc_q} + {1'b0, div_frac_i};
      os_tick_d             = 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + {{DIV_W{1'b0}}, 1'b1};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pre_cnt_q  <= '0;
      frac_acc_q <= '0;
      carry_q    <= 1'b0;
      os_tick_q  <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      frac_acc_q <= frac_acc_d;
      carry_q    <= carry_d;
      os_tick_q  <= os_tick_d;
    end
  end

  assign wrap_o    = wrap;
  assign os_tick_o = os_tick_q;

endmodule

// File: rtl/uart_baud_gen_os.sv
// UART baud generator: shared fractional prescaler feeding TX bit ticks and
// RX mid-bit sample strobes, with RX phase re-alignment on each start edge.
module uart_baud_gen_os
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned FRAC_W  = FRAC_W_DEF,
  parameter int unsigned OS_RATE = OS_RATE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              tx_tick,
  output logic              rx_sample,
  output logic              cfg_err,
  output logic              busy
);

  localparam int unsigned     OsW    = $clog2(OS_RATE);
  localparam logic [OsW-1:0]  OsLast = OsW'(OS_RATE - 1);
  localparam logic [OsW-1:0]  OsMid  = OsW'(OS_RATE / 2 - 1);
  localparam logic [OsW-1:0]  OsOne  = OsW'(1);

  if (!os_rate_ok(OS_RATE)) begin : g_os_rate_check
    $error("OS_RATE must be a power of 2 and >= 4");
  end

  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [OsW-1:0]    tx_os_cnt_q, tx_os_cnt_d;
  logic [OsW-1:0]    rx_os_cnt_q, rx_os_cnt_d;
  logic              tx_tick_q, tx_tick_d;
  logic              rx_sample_q, rx_sample_d;
  logic              cfg_err_q, cfg_err_d;
  logic              busy_q, busy_d;
  logic              run;
  logic              wrap;

  assign run = tx_en | rx_en;

  baud_frac_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_prescaler (
    .clock_i    (clock),
    .reset_i    (reset),
    .en_i       (run),
    .div_int_i  (div_int_q),
    .div_frac_i (div_frac_q),
    .wrap_o     (wrap),
    .os_tick_o  (os_tick)
  );

  // Next-state: divisor load/reject, TX bit phase, RX bit phase.
  always_comb begin
    div_int_d   = div_int_q;
    div_frac_d  = div_frac_q;
    cfg_err_d   = 1'b0;
    busy_d      = run;
    tx_os_cnt_d = tx_os_cnt_q;
    tx_tick_d   = 1'b0;
    rx_os_cnt_d = rx_os_cnt_q;
    rx_sample_d = 1'b0;

    // The divisor is frozen while any timing is active.
    if (cfg_wr) begin
      if (busy_q) begin
        cfg_err_d = 1'b1;
      end else begin
        div_int_d  = div_int;
        div_frac_d = div_frac;
      end
    end

    if (!tx_en) begin
      tx_os_cnt_d = '0;
    end else if (wrap) begin
      tx_os_cnt_d = tx_os_cnt_q + OsOne;
      tx_tick_d   = (tx_os_cnt_q == OsLast);
    end

    // Resync only realigns the RX phase; the prescaler keeps its phase.
    if (!rx_en || rx_resync) begin
      rx_os_cnt_d = '0;
    end else if (wrap) begin
      rx_os_cnt_d = rx_os_cnt_q + OsOne;
      rx_sample_d = (rx_os_cnt_q == OsMid);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_int_q   <= '0;
      div_frac_q  <= '0;
      tx_os_cnt_q <= '0;
      rx_os_cnt_q <= '0;
      tx_tick_q   <= 1'b0;
      rx_sample_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_int_q   <= div_int_d;
      div_frac_q  <= div_frac_d;
      tx_os_cnt_q <= tx_os_cnt_d;
      rx_os_cnt_q <= rx_os_cnt_d;
      tx_tick_q   <= tx_tick_d;
      rx_sample_q <= rx_sample_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_tick   = tx_tick_q;
  assign rx_sample = rx_sample_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_baud_gen_os.sv
// Bench for uart_baud_gen_os: per-cycle reference model, a table of divisor
// settings with known tick timing, directed RX/config/reset sequences, random episodes.
module tb_uart_baud_gen_os;

  localparam int unsigned DW  = 8;
  localparam int unsigned FW  = 4;
  localparam int unsigned OSR = 16;

  logic          clock = 1'b0;
  logic          reset, cfg_wr, tx_en, rx_en, rx_resync;
  logic [DW-1:0] div_int;
  logic [FW-1:0] div_frac;
  logic          os_tick, tx_tick, rx_sample, cfg_err, busy;

  always #5 clock = ~clock;

  uart_baud_gen_os #(
    .DIV_W   (DW),
    .FRAC_W  (FW),
    .OS_RATE (OSR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_wr    (cfg_wr),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .rx_resync (rx_resync),
    .os_tick   (os_tick),
    .tx_tick   (tx_tick),
    .rx_sample (rx_sample),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state. Oversample wraps are placed by closed form: the n-th
  // wrap after enable lands n*(div+1) + floor((n-1)*frac/2^FW) - 1 clocks in.
  longint unsigned cyc = 0;
  longint unsigned m_start = 0;
  longint unsigned m_n = 1;
  longint unsigned m_div = 0;
  longint unsigned m_frac = 0;
  bit              m_busy = 1'b0;
  bit              m_run_prev = 1'b0;
  int unsigned     m_tx_w = 0;
  int unsigned     m_rx_w = 0;
  logic [4:0]      exp_out = '0;
  bit              drv_prev = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: actual %0h, required %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_step();
    bit run, wrap, tx_t, rx_s, err;
    longint unsigned nxt;
    run  = tx_en | rx_en;
    wrap = 1'b0;
    tx_t = 1'b0;
    rx_s = 1'b0;
    err  = 1'b0;
    if (reset) begin
      m_div = 0; m_frac = 0; m_busy = 1'b0; m_run_prev = 1'b0;
      m_tx_w = 0; m_rx_w = 0; exp_out = '0;
      return;
    end
    if (run) begin
      if (!m_run_prev) begin
        m_start = cyc;
        m_n     = 1;
      end
      nxt = m_start + m_n * (m_div + 1) + (((m_n - 1) * m_frac) >> FW) - 1;
      if (cyc == nxt) begin
        wrap = 1'b1;
        m_n++;
      end
    end
    if (!tx_en) m_tx_w = 0;
    else if (wrap) begin
      m_tx_w++;
      tx_t = (m_tx_w % OSR) == 0;
    end
    if (!rx_en || rx_resync) m_rx_w = 0;
    else if (wrap) begin
      m_rx_w++;
      rx_s = (m_rx_w % OSR) == OSR / 2;
    end
    if (cfg_wr) begin
      if (m_busy) err = 1'b1;
      else begin
        m_div  = div_int;
        m_frac = div_frac;
      end
    end
    m_busy     = run;
    m_run_prev = run;
    exp_out    = {wrap, tx_t, rx_s, err, run};
  endfunction

  // Drive one clock of inputs, advance the model, compare all outputs.
  task automatic step(bit rst, bit cw, int di, int df, bit te, bit re, bit rs);
    reset     = rst;
    cfg_wr    = cw;
    div_int   = di[DW-1:0];
    div_frac  = df[FW-1:0];
    tx_en     = te;
    rx_en     = re;
    rx_resync = rs;
    @(posedge clock);
    model_step();
    cyc++;
    drv_prev = rst ? 1'b0 : (te | re);
    #1;
    check("outs{os,tx,rx,err,busy}", {os_tick, tx_tick, rx_sample, cfg_err, busy}, exp_out);
  endtask

  task automatic setup(int di, int df);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, di, df, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Edges from tx_en rise to first tx_tick, then to the next one; -1 if none.
  task automatic measure_tx(int di, int df, output int first, output int spacing);
    int k;
    setup(di, df);
    first   = -1;
    spacing = -1;
    k = 0;
    while (first < 0 && k < 20000) begin
      k++;
      step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      if (tx_tick) first = k;
    end
    k = 0;
    while (spacing < 0 && k < 20000) begin
      k++;
      step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      if (tx_tick) spacing = k;
    end
  endtask

  typedef struct {
    int di;
    int df;
    int first;
    int spacing;
  } row_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[6];
    int   first, spacing;
    int   ticks[$];
    int   samples[$];
    int   exp_rx[3];
    int   exp_tx[3];

    rows[0] = '{3, 0, 64, 64};
    rows[1] = '{3, 8, 71, 72};
    rows[2] = '{0, 0, 16, 16};
    rows[3] = '{2, 4, 51, 52};
    rows[4] = '{1, 15, 46, 47};
    rows[5] = '{255, 15, 4110, 4111};

    // Reset state.
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("reset_state", {os_tick, tx_tick, rx_sample, cfg_err, busy}, 5'b0);

    // Divisor table: first TX tick latency and TX tick spacing.
    for (int i = 0; i < 6; i++) begin
      measure_tx(rows[i].di, rows[i].df, first, spacing);
      check($sformatf("tx_first[div=%0d,frac=%0d]", rows[i].di, rows[i].df), first,
            rows[i].first);
      check($sformatf("tx_spacing[div=%0d,frac=%0d]", rows[i].di, rows[i].df), spacing,
            rows[i].spacing);
    end

    // RX: resync mid-bit, second resync, resync coincident with a sampling wrap.
    exp_rx = '{35, 79, 175};
    setup(3, 0);
    for (int e = 0; e <= 200; e++) begin
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, (e == 5) || (e == 50) || (e == 143));
      if (rx_sample) samples.push_back(e);
    end
    check("rx_sample_count", samples.size(), 3);
    for (int i = 0; i < 3 && i < samples.size(); i++) check("rx_sample_edge", samples[i], exp_rx[i]);

    // Config write while running is rejected and leaves TX timing untouched.
    exp_tx = '{64, 128, 192};
    setup(3, 0);
    for (int e = 1; e <= 200; e++) begin
      step(1'b0, (e == 70), 0, 5, 1'b1, (e > 100), 1'b0);
      if (e == 70) check("cfg_err_when_busy", cfg_err, 1);
      if (e == 71) check("cfg_err_one_cycle", cfg_err, 0);
      if (tx_tick) ticks.push_back(e);
    end
    check("tx_tick_count_busy_cfg", ticks.size(), 3);
    for (int i = 0; i < 3 && i < ticks.size(); i++) check("tx_tick_edge", ticks[i], exp_tx[i]);

    // Reset mid-frame clears all outputs; re-enable restarts timing from scratch.
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("reset_mid_frame", {os_tick, tx_tick, rx_sample, cfg_err, busy}, 5'b0);
    measure_tx(3, 0, first, spacing);
    check("tx_first_after_reset", first, 64);

    // Random episodes against the reference model.
    for (int ep = 0; ep < 40; ep++) begin
      bit te, re, rs, cw;
      int len;
      for (int i = 0; i < int'($urandom_range(2, 4)); i++)
        step((ep % 9 == 0) && (i == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 12),
             $urandom_range(0, 15), 1'b0, 1'b0, 1'b0);
      te  = 1'($urandom_range(0, 1));
      re  = te ? 1'($urandom_range(0, 1)) : 1'b1;
      len = $urandom_range(100, 600);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 63) == 0) te = ~te;
        if ($urandom_range(0, 63) == 0) re = ~re;
        rs = re && ($urandom_range(0, 39) == 0);
        // Never load on the very edge the prescaler starts up.
        cw = ($urandom_range(0, 49) == 0) && !((te | re) && !drv_prev);
        step(1'b0, cw, $urandom_range(0, 12), $urandom_range(0, 15), te, re, rs);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
